hdlc_rx_drain_ctrl: RTL and testbench
=====================================

# hdlc_rx_drain_ctrl

Bus-master controller that sits between the HDLC core's 8-bit register interface and a downstream byte-stream consumer. It polls the Rx status/control register, drains each good frame from the Rx buffer onto a valid/ready stream, and discards bad frames by issuing Rx_Drop. It takes the place of the CPU-side polling loop, so the HDLC core needs no software attention during reception.

## Interface
- POLL_GAP, 4: idle cycles between consecutive status polls (1..255)
- ADDR_RXSC, 3'h2: Rx status/control register address
- ADDR_RXBUF, 3'h3: Rx data buffer address
- ADDR_RXLEN, 3'h4: Rx frame length register address

Ports:
- Clk  in  1  system clock; all logic on posedge
- Rst  in  1  synchronous reset, active-high
- Enable  in  1  permits new polls; sampled only in IDLE
- Address  out  3  HDLC register address
- ReadEnable  out  1  one-cycle read strobe
- WriteEnable  out  1  one-cycle write strobe
- DataIn  out  8  write data to HDLC core
- DataOut  in  8  read data from HDLC core; valid the cycle after ReadEnable
- M_Valid  out  1  stream byte valid
- M_Data  out  8  stream byte
- M_Last  out  1  final byte of frame, qualified by M_Valid
- M_Ready  in  1  consumer accepts byte when M_Valid && M_Ready
- FrameDone  out  1  one-cycle pulse after last byte accepted
- FrameDropped  out  1  one-cycle pulse after Rx_Drop written
- Busy  out  1  high in any state except IDLE

## Operation
- Rx_SC bits: [0] Rx_Ready, [1] Rx_Drop (write 1), [2] Rx_FrameError, [3] Rx_AbortSignal, [4] Rx_Overflow.
- States: IDLE, POLL, POLL_WAIT, GAP, LEN, LEN_WAIT, RD, RD_WAIT, HOLD, DROP, DONE.
- IDLE: if Enable, go to POLL.
- POLL: ReadEnable=1, Address=ADDR_RXSC; go to POLL_WAIT.
- POLL_WAIT: sample DataOut.
  - If [0]=0: go to GAP.
  - If [0]=1 and any of [4:2] set: go to DROP.
  - Otherwise: go to LEN.
- GAP: count POLL_GAP cycles, then go to IDLE.
- LEN: read ADDR_RXLEN; in LEN_WAIT, latch remaining count. Length 0 goes to DROP; otherwise go to RD.
- RD: read ADDR_RXBUF. RD_WAIT: load DataOut into M_Data, set M_Valid=1, set M_Last=(remaining==1), decrement remaining; go to HOLD.
- HOLD: wait for M_Ready. On accept: M_Valid=0; if the byte was last, go to DONE, else go to RD.
- DROP: WriteEnable=1, Address=ADDR_RXSC, DataIn=8'h02; FrameDropped=1; go to GAP.
- DONE: FrameDone=1; go to IDLE.
- Enable deasserted mid-frame: the current frame completes or drops normally; no new poll is issued.
- Only one of ReadEnable/WriteEnable is high in any cycle. Address holds its last value when neither strobe is high.
- The remaining counter is 8 bits; lengths 1..128 are legal.

## Timing
- Reset values:
  - All outputs 0; Address=3'h0.
  - State=IDLE; counters 0.
- Synchronous Rst asserted mid-frame: next cycle all outputs 0, M_Valid drops without handshake, and state=IDLE. No Rx_Drop is issued; the HDLC core is reset on the same line.
- Status poll to decision: 2 cycles (POLL, POLL_WAIT).
- Ready seen to first M_Valid: 4 cycles (LEN, LEN_WAIT, RD, RD_WAIT).
- Per-byte cost with M_Ready tied high: 3 cycles (RD, RD_WAIT, HOLD).
- M_Data and M_Last are stable while M_Valid=1 and M_Ready=0.
- FrameDone asserts the cycle after the last byte's handshake.
- Ready seen to DROP write: 1 cycle after POLL_WAIT.

## Configuration
- HDLC_RXDRAIN_STATS_EN defined: adds output ports FrameOkCnt[15:0] and FrameDropCnt[15:0].
  - Each increments on FrameDone and FrameDropped respectively.
  - Both saturate at 16'hFFFF and reset to 0.
- HDLC_RXDRAIN_STATS_EN undefined: these ports and their counters are absent; all other behaviour is identical.

## Test plan
- Good 3-byte frame: Rx_SC=8'h01, Rx_Len=3, data 8'hA5, 8'h5A, 8'h7E; M_Ready=1 → stream A5, 5A, 7E, with M_Last only on 7E; FrameDone pulses once; no WriteEnable.
- FCS error: Rx_SC=8'h05 → one write to Address=2 with DataIn=8'h02 two cycles after ReadEnable; FrameDropped pulses; M_Valid stays 0.
- Backpressure: 2-byte frame with M_Ready low for 5 cycles on byte 1 → M_Data/M_Valid held constant; no ReadEnable issued during the stall.
- Idle polling with POLL_GAP=4 and Rx_SC=8'h00 → ReadEnable to Address=2 every 7 cycles; Busy high except in IDLE.
- Max length: Rx_Len=128 → exactly 128 handshakes, M_Last on the 128th; Rx_Len=0 with Ready → drop write issued.
- Rst pulsed while in HOLD on byte 2 of 4 → next cycle M_Valid=0 and Busy=0; a subsequent frame drains correctly from byte 1.

Source files
------------

// File: rtl/hdlc_rx_drain_ctrl_if.sv
// Bundle for hdlc_rx_drain_ctrl: the HDLC core register bus plus the
// outgoing byte stream. master = drain controller side, slave = HDLC core
// and stream consumer side.
interface hdlc_rx_drain_ctrl_if;
  logic [2:0] Address;
  logic       ReadEnable;
  logic       WriteEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut;
  logic       M_Valid;
  logic [7:0] M_Data;
  logic       M_Last;
  logic       M_Ready;

  modport master (
    output Address, ReadEnable, WriteEnable, DataIn,
    output M_Valid, M_Data, M_Last,
    input  DataOut, M_Ready
  );

  modport slave (
    input  Address, ReadEnable, WriteEnable, DataIn,
    input  M_Valid, M_Data, M_Last,
    output DataOut, M_Ready
  );
endinterface

// File: rtl/hdlc_rx_drain_ctrl.sv
// hdlc_rx_drain_ctrl: polls the HDLC Rx status register, streams good frames
// out of the Rx buffer on a valid/ready byte stream and drops bad frames by
// writing Rx_Drop. Optional frame statistics are enabled with the macro
// HDLC_RXDRAIN_STATS_EN (adds FrameOkCnt / FrameDropCnt).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for Enable before the next status poll
// POLL      | read strobe on Rx_SC
// POLL_WAIT | status byte on DataOut; decide gap / drop / drain
// GAP       | POLL_GAP idle cycles between polls
// LEN       | read strobe on Rx_Len
// LEN_WAIT  | latch frame length; zero length is treated as bad
// RD        | read strobe on Rx buffer
// RD_WAIT   | present buffer byte on the stream
// HOLD      | wait for consumer handshake
// DROP      | write Rx_Drop to Rx_SC
// DONE      | frame fully drained, pulse FrameDone
module hdlc_rx_drain_ctrl #(
  parameter int unsigned POLL_GAP   = 4,
  parameter logic [2:0]  ADDR_RXSC  = 3'h2,
  parameter logic [2:0]  ADDR_RXBUF = 3'h3,
  parameter logic [2:0]  ADDR_RXLEN = 3'h4
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      Enable,
  hdlc_rx_drain_ctrl_if.master      bus,
  output logic                      FrameDone,
  output logic                      FrameDropped,
  output logic                      Busy
`ifdef HDLC_RXDRAIN_STATS_EN
  ,
  output logic [15:0]               FrameOkCnt,
  output logic [15:0]               FrameDropCnt
`endif
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_POLL      = 4'd1;
  localparam logic [3:0] S_POLL_WAIT = 4'd2;
  localparam logic [3:0] S_GAP       = 4'd3;
  localparam logic [3:0] S_LEN       = 4'd4;
  localparam logic [3:0] S_LEN_WAIT  = 4'd5;
  localparam logic [3:0] S_RD        = 4'd6;
  localparam logic [3:0] S_RD_WAIT   = 4'd7;
  localparam logic [3:0] S_HOLD      = 4'd8;
  localparam logic [3:0] S_DROP      = 4'd9;
  localparam logic [3:0] S_DONE      = 4'd10;

  // GAP is a down-counter ending at zero, so it is loaded with one less
  // than the number of gap cycles.
  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP - 1);

  logic [3:0] state;
  logic [7:0] gap_cnt;
  logic [7:0] remaining;
  logic [2:0] address;
  logic       read_en;
  logic       write_en;
  logic [7:0] data_in;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       frame_done;
  logic       frame_dropped;

  assign bus.Address     = address;
  assign bus.ReadEnable  = read_en;
  assign bus.WriteEnable = write_en;
  assign bus.DataIn      = data_in;
  assign bus.M_Valid     = m_valid;
  assign bus.M_Data      = m_data;
  assign bus.M_Last      = m_last;
  assign FrameDone       = frame_done;
  assign FrameDropped    = frame_dropped;
  assign Busy            = (state != S_IDLE);

  // Sequencer: outputs are registered together with the state they belong
  // to, so strobes and pulses line up exactly with their state cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state         <= S_IDLE;
      gap_cnt       <= '0;
      remaining     <= '0;
      address       <= '0;
      read_en       <= 1'b0;
      write_en      <= 1'b0;
      data_in       <= '0;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_last        <= 1'b0;
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
    end else begin
      read_en       <= 1'b0;
      write_en      <= 1'b0;
      data_in       <= '0;
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Enable) begin
            state   <= S_POLL;
            read_en <= 1'b1;
            address <= ADDR_RXSC;
          end
        end
        S_POLL: state <= S_POLL_WAIT;
        S_POLL_WAIT: begin
          if (!bus.DataOut[0]) begin
            state   <= S_GAP;
            gap_cnt <= GAP_LOAD;
          end else if (|bus.DataOut[4:2]) begin
            state         <= S_DROP;
            write_en      <= 1'b1;
            address       <= ADDR_RXSC;
            data_in       <= 8'h02;
            frame_dropped <= 1'b1;
          end else begin
            state   <= S_LEN;
            read_en <= 1'b1;
            address <= ADDR_RXLEN;
          end
        end
        S_GAP: begin
          if (gap_cnt == 8'd0) state <= S_IDLE;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        S_LEN: state <= S_LEN_WAIT;
        S_LEN_WAIT: begin
          remaining <= bus.DataOut;
          if (bus.DataOut == 8'd0) begin
            state         <= S_DROP;
            write_en      <= 1'b1;
            address       <= ADDR_RXSC;
            data_in       <= 8'h02;
            frame_dropped <= 1'b1;
          end else begin
            state   <= S_RD;
            read_en <= 1'b1;
            address <= ADDR_RXBUF;
          end
        end
        S_RD: state <= S_RD_WAIT;
        S_RD_WAIT: begin
          m_data    <= bus.DataOut;
          m_valid   <= 1'b1;
          m_last    <= (remaining == 8'd1);
          remaining <= remaining - 8'd1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.M_Ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              state      <= S_DONE;
              frame_done <= 1'b1;
            end else begin
              state   <= S_RD;
              read_en <= 1'b1;
              address <= ADDR_RXBUF;
            end
          end
        end
        S_DROP: begin
          state   <= S_GAP;
          gap_cnt <= GAP_LOAD;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HDLC_RXDRAIN_STATS_EN
  // Saturating frame counters, bumped by the completion/drop pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      FrameOkCnt   <= '0;
      FrameDropCnt <= '0;
    end else begin
      if (frame_done && (FrameOkCnt != 16'hFFFF))
        FrameOkCnt <= FrameOkCnt + 16'd1;
      if (frame_dropped && (FrameDropCnt != 16'hFFFF))
        FrameDropCnt <= FrameDropCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdlc_rx_drain_ctrl.sv
// Testbench for hdlc_rx_drain_ctrl: a behavioural HDLC Rx core (frame store
// with status/length/buffer registers) feeds the DUT; a scoreboard holds the
// stream bytes, completions and drops each frame should produce.
module tb_hdlc_rx_drain_ctrl;

  localparam int         POLL_GAP   = 4;
  localparam logic [2:0] ADDR_RXSC  = 3'h2;
  localparam logic [2:0] ADDR_RXBUF = 3'h3;
  localparam logic [2:0] ADDR_RXLEN = 3'h4;
  localparam int         K_BYTE = 0, K_DONE = 1, K_DROP = 2;
  localparam int         MAXF = 64;

  typedef struct {
    int         kind;
    logic [7:0] data;
    logic       last;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic frame_done, frame_dropped, busy;
`ifdef HDLC_RXDRAIN_STATS_EN
  logic [15:0] ok_cnt, drop_cnt;
`endif

  hdlc_rx_drain_ctrl_if bus ();

  hdlc_rx_drain_ctrl #(
    .POLL_GAP(POLL_GAP), .ADDR_RXSC(ADDR_RXSC),
    .ADDR_RXBUF(ADDR_RXBUF), .ADDR_RXLEN(ADDR_RXLEN)
  ) dut (
    .Clk(clk), .Rst(rst), .Enable(enable), .bus(bus),
    .FrameDone(frame_done), .FrameDropped(frame_dropped), .Busy(busy)
`ifdef HDLC_RXDRAIN_STATS_EN
    , .FrameOkCnt(ok_cnt), .FrameDropCnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // frame store of the modelled HDLC core
  logic [7:0] st_mem  [MAXF];
  int         len_mem [MAXF];
  logic [7:0] dat_mem [MAXF][128];
  logic [7:0] stage   [128];
  int         n_frames = 0;
  int         head = 0;
  int         rd_idx = 0;

  exp_t exp_q[$];

  // monitor state
  int   cyc = 0, last_poll = 0, last_hs = 0, n_polls = 0, hs_cnt = 0, stall_cnt = 0;
  bit   seen_poll = 0, poll_chk = 0, prev_stall = 0, prev_valid = 0;
  logic [7:0] prev_data;
  logic prev_last;
  int   seen_ok = 0, seen_drop = 0;

  // ready driver control
  int rdy_mode = 0;
  int stall_idx = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: decide the frame's fate from its status and length.
  task automatic add_frame(input logic [7:0] st, input int len);
    exp_t e;
    st_mem[n_frames]  = st;
    len_mem[n_frames] = len;
    for (int j = 0; j < len; j++) dat_mem[n_frames][j] = stage[j];
    if (st[4:2] != 3'b000) begin
      e = '{K_DROP, 8'h00, 1'b0, 2};
      exp_q.push_back(e);
    end else if (len == 0) begin
      e = '{K_DROP, 8'h00, 1'b0, 4};
      exp_q.push_back(e);
    end else begin
      for (int j = 0; j < len; j++) begin
        e = '{K_BYTE, stage[j], (j == len - 1), 0};
        exp_q.push_back(e);
      end
      e = '{K_DONE, 8'h00, 1'b0, 0};
      exp_q.push_back(e);
    end
    n_frames++;
  endtask

  task automatic fill_random(input int len);
    for (int j = 0; j < len; j++) stage[j] = 8'($urandom);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_drain_timeout"}, int'(k < budget), 1);
  endtask

  task automatic wait_valid(input string name, input int nth, input int budget);
    int k = 0;
    while (!(bus.M_Valid && hs_cnt == nth) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_valid_timeout"}, int'(k < budget), 1);
  endtask

  // HDLC core register model: read data appears the cycle after ReadEnable.
  always @(posedge clk) begin
    if (rst) begin
      head        <= n_frames;
      rd_idx      <= 0;
      bus.DataOut <= 8'h00;
    end else begin
      if (bus.ReadEnable) begin
        if (bus.Address == ADDR_RXSC)
          bus.DataOut <= (head < n_frames) ? st_mem[head] : 8'h00;
        else if (bus.Address == ADDR_RXLEN && head < n_frames)
          bus.DataOut <= 8'(len_mem[head]);
        else if (bus.Address == ADDR_RXBUF && head < n_frames) begin
          bus.DataOut <= dat_mem[head][rd_idx];
          if (rd_idx + 1 >= len_mem[head]) begin
            head   <= head + 1;
            rd_idx <= 0;
          end else
            rd_idx <= rd_idx + 1;
        end
      end
      if (bus.WriteEnable && bus.Address == ADDR_RXSC && bus.DataIn[1] && head < n_frames) begin
        head   <= head + 1;
        rd_idx <= 0;
      end
    end
  end

  // consumer ready generator
  initial begin
    bus.M_Ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.M_Ready = 1'b1;
        1:       bus.M_Ready = ($urandom_range(0, 3) != 0);
        default: bus.M_Ready = (hs_cnt != stall_idx);
      endcase
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t it;
    cyc++;
    if (rst) begin
      hs_cnt     = 0;
      prev_stall = 0;
      prev_valid = 0;
      seen_poll  = 0;
    end else begin
      chk("strobe_exclusive", int'(bus.ReadEnable & bus.WriteEnable), 0);
      if (bus.ReadEnable && bus.Address == ADDR_RXSC) begin
        if (poll_chk && seen_poll) chk("poll_period", cyc - last_poll, 7);
        last_poll = cyc;
        seen_poll = 1;
        n_polls++;
      end
      if (poll_chk && seen_poll) chk("busy_idle_poll", int'(busy), int'((cyc - last_poll) != 6));
      if (prev_stall) begin
        chk("stall_valid_held", int'(bus.M_Valid), 1);
        chk("stall_data_held", int'(bus.M_Data), int'(prev_data));
        chk("stall_last_held", int'(bus.M_Last), int'(prev_last));
      end
      if (bus.M_Valid && !bus.M_Ready) begin
        chk("stall_no_read", int'(bus.ReadEnable), 0);
        stall_cnt++;
      end
      if (bus.M_Valid && !prev_valid) begin
        if (hs_cnt == 0) chk("first_valid_latency", cyc - last_poll, 6);
        else             chk("byte_spacing", cyc - last_hs, 3);
      end
      if (bus.M_Valid && bus.M_Ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", int'(bus.M_Data), -1);
        else begin
          it = exp_q.pop_front();
          chk("byte_kind", K_BYTE, it.kind);
          chk("byte_data", int'(bus.M_Data), int'(it.data));
          chk("byte_last", int'(bus.M_Last), int'(it.last));
        end
        last_hs = cyc;
        hs_cnt++;
      end
      if (frame_done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          it = exp_q.pop_front();
          chk("done_kind", K_DONE, it.kind);
          chk("done_latency", cyc - last_hs, 1);
          seen_ok++;
        end
        hs_cnt = 0;
      end
      if (bus.WriteEnable || frame_dropped) begin
        if (exp_q.size() == 0) chk("unexpected_drop", 1, 0);
        else begin
          it = exp_q.pop_front();
          chk("drop_kind", K_DROP, it.kind);
          chk("drop_write", int'(bus.WriteEnable), 1);
          chk("drop_pulse", int'(frame_dropped), 1);
          chk("drop_addr", int'(bus.Address), int'(ADDR_RXSC));
          chk("drop_data", int'(bus.DataIn), 8'h02);
          chk("drop_latency", cyc - last_poll, it.lat);
          seen_drop++;
        end
      end
      prev_stall = bus.M_Valid && !bus.M_Ready;
      prev_valid = bus.M_Valid;
      prev_data  = bus.M_Data;
      prev_last  = bus.M_Last;
    end
  end

  initial begin
    int p;
    logic [7:0] st;
    int len;
    rst    = 1'b1;
    enable = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_address", int'(bus.Address), 0);
    chk("rst_read", int'(bus.ReadEnable), 0);
    chk("rst_write", int'(bus.WriteEnable), 0);
    chk("rst_datain", int'(bus.DataIn), 0);
    chk("rst_mvalid", int'(bus.M_Valid), 0);
    chk("rst_mdata", int'(bus.M_Data), 0);
    chk("rst_mlast", int'(bus.M_Last), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_dropped", int'(frame_dropped), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    // idle polling with an empty core
    enable   = 1'b1;
    poll_chk = 1;
    repeat (50) @(negedge clk);
    poll_chk = 0;
    chk("idle_poll_count", int'(n_polls >= 6), 1);

    // good 3-byte frame
    rdy_mode = 0;
    stage[0] = 8'hA5; stage[1] = 8'h5A; stage[2] = 8'h7E;
    add_frame(8'h01, 3);
    wait_drain("good3", 200);

    // FCS error
    fill_random(4);
    add_frame(8'h05, 4);
    wait_drain("fcs", 200);

    // backpressure on byte 1 of a 2-byte frame
    rdy_mode  = 3;
    stall_idx = 0;
    stall_cnt = 0;
    fill_random(2);
    add_frame(8'h01, 2);
    wait_valid("bp", 0, 200);
    repeat (5) @(negedge clk);
    rdy_mode = 0;
    wait_drain("bp", 200);
    chk("bp_stall_cycles", int'(stall_cnt >= 5), 1);

    // maximum length, then zero length with Rx_Ready
    fill_random(128);
    add_frame(8'h01, 128);
    wait_drain("max_len", 2000);
    add_frame(8'h01, 0);
    wait_drain("zero_len", 200);

    // Enable dropped mid-frame: frame finishes, no further polls
    fill_random(3);
    add_frame(8'h01, 3);
    wait_valid("en_off", 0, 200);
    enable = 1'b0;
    wait_drain("en_off", 200);
    p = n_polls;
    repeat (30) @(negedge clk);
    chk("en_off_no_poll", n_polls, p);
    chk("en_off_busy", int'(busy), 0);
    enable = 1'b1;

    // reset while holding byte 2 of 4
    rdy_mode  = 3;
    stall_idx = 1;
    fill_random(4);
    add_frame(8'h01, 4);
    wait_valid("rst_hold", 1, 300);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_hold_mvalid", int'(bus.M_Valid), 0);
    chk("rst_hold_busy", int'(busy), 0);
    rst = 1'b0;
    exp_q.delete();
    rdy_mode = 0;
    fill_random(4);
    add_frame(8'h01, 4);
    wait_drain("after_rst", 300);

    // randomized frames with random backpressure
    rdy_mode = 1;
    for (int f = 0; f < 20; f++) begin
      st = 8'($urandom);
      st[0] = 1'b1;
      if ($urandom_range(0, 2) != 0) st[4:2] = 3'b000;
      len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
      fill_random(len);
      add_frame(st, len);
    end
    wait_drain("random", 20000);
    rdy_mode = 0;

`ifdef HDLC_RXDRAIN_STATS_EN
    chk("stats_ok", int'(ok_cnt), seen_ok);
    chk("stats_drop", int'(drop_cnt), seen_drop);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
